// File: rtl/meter_pkg.sv
// Shared types, default parameters and a width helper for the signal meter.
package meter_pkg;

    typedef logic [31:0] u32;

    localparam int W_DEF    = 32;
    localparam u32 GATE_DEF = 32'd31_250_000;

    // Counter width for values 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input u32 v);
        if (v > 32'd1) begin
            return $clog2(v);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/word_stats.sv
// Combinational per-word statistics for one W-sample word plus the preceding sample.
// SIG_METER_MINMAX_EN adds min/max of interior high runs.
import meter_pkg::*;

module word_stats #(
    parameter int W     = W_DEF,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic             prev,
    input  logic [W-1:0]     smp,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] ones_cnt,
    output logic             trans,
    output logic [CNT_W-1:0] lead_len,
    output logic [CNT_W-1:0] trail_len,
    output logic [CNT_W-1:0] int_hi,
    output logic [CNT_W-1:0] int_lo
`ifdef SIG_METER_MINMAX_EN
    ,
    output logic [CNT_W-1:0] int_hi_min,
    output logic [CNT_W-1:0] int_hi_max
`endif
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);

    // Scan oldest to newest; interior runs lie between two transitions inside this word.
    always_comb begin : p_scan
        logic pb;
        logic seen;
        int   first_k;
        int   last_k;
        rise_cnt = ZERO;
        ones_cnt = ZERO;
        int_hi   = ZERO;
        int_lo   = ZERO;
`ifdef SIG_METER_MINMAX_EN
        int_hi_min = {CNT_W{1'b1}};
        int_hi_max = ZERO;
`endif
        pb      = prev;
        seen    = 1'b0;
        first_k = W;
        last_k  = 0;
        for (int i = 0; i < W; i++) begin
            ones_cnt = ones_cnt + (smp[i] ? ONE : ZERO);
            if (smp[i] != pb) begin
                rise_cnt = rise_cnt + (smp[i] ? ONE : ZERO);
                if (seen) begin
                    if (pb) begin
                        int_hi = CNT_W'(i - last_k);
`ifdef SIG_METER_MINMAX_EN
                        if (CNT_W'(i - last_k) < int_hi_min) begin
                            int_hi_min = CNT_W'(i - last_k);
                        end else begin
                            int_hi_min = int_hi_min;
                        end
                        if (CNT_W'(i - last_k) > int_hi_max) begin
                            int_hi_max = CNT_W'(i - last_k);
                        end else begin
                            int_hi_max = int_hi_max;
                        end
`endif
                    end else begin
                        int_lo = CNT_W'(i - last_k);
                    end
                end else begin
                    first_k = i;
                end
                seen   = 1'b1;
                last_k = i;
            end else begin
                seen = seen;
            end
            pb = smp[i];
        end
        trans     = seen;
        lead_len  = CNT_W'(first_k);
        trail_len = CNT_W'(W - last_k);
    end

endmodule

// File: rtl/sig_meter.sv
// Windowed frequency / duty / pulse-width meter over a stream of W-sample words.
// SIG_METER_MINMAX_EN enables hi_min/hi_max tracking of completed high runs.
import meter_pkg::*;

module sig_meter #(
    parameter int W    = W_DEF,
    parameter u32 GATE = GATE_DEF,
    parameter int CW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          smp_vld,
    input  logic [W-1:0]  smp,
    input  logic          clr,
    output logic [CW-1:0] freq,
    output logic [CW-1:0] duty,
    output logic [CW-1:0] t_hi,
    output logic [CW-1:0] t_lo,
    output logic [CW-1:0] hi_min,
    output logic [CW-1:0] hi_max,
    output logic          res_vld
);

    localparam int CNT_W = $clog2(W + 1);
    localparam int WC_W  = clog2_min1(GATE);
    localparam int CW1   = CW + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(GATE - 32'd1);
    localparam logic [CW-1:0]   SAT     = {CW{1'b1}};

    logic [CNT_W-1:0] rise_cnt_s, ones_cnt_s, lead_len_s, trail_len_s, int_hi_s, int_lo_s;
    logic             trans_s;
`ifdef SIG_METER_MINMAX_EN
    logic [CNT_W-1:0] int_hi_min_s, int_hi_max_s;
`endif

    logic            prev_q, prev_d;
    logic            first_q, first_d;
    logic [CW-1:0]   run_q, run_d;
    logic [CW-1:0]   acc_r_q, acc_r_d, acc_1_q, acc_1_d;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0]   freq_q, freq_d, duty_q, duty_d;
    logic [CW-1:0]   t_hi_q, t_hi_d, t_lo_q, t_lo_d;
    logic            res_vld_q, res_vld_d;

    logic [CW1-1:0]  lead_sum_s, word_sum_s;
    logic [CW-1:0]   lead_run_s, run_word_s;
    logic            accept_s, win_end_s, lead_hi_done_s;

    word_stats #(.W(W), .CNT_W(CNT_W)) u_stats (
        .prev      (prev_q),
        .smp       (smp),
        .rise_cnt  (rise_cnt_s),
        .ones_cnt  (ones_cnt_s),
        .trans     (trans_s),
        .lead_len  (lead_len_s),
        .trail_len (trail_len_s),
        .int_hi    (int_hi_s),
        .int_lo    (int_lo_s)
`ifdef SIG_METER_MINMAX_EN
        ,
        .int_hi_min(int_hi_min_s),
        .int_hi_max(int_hi_max_s)
`endif
    );

    // Saturating extensions of the carried run: up to the first transition, or the whole word.
    always_comb begin
        lead_sum_s     = {1'b0, run_q} + CW1'(lead_len_s);
        word_sum_s     = {1'b0, run_q} + CW1'(W);
        lead_run_s     = lead_sum_s[CW] ? SAT : lead_sum_s[CW-1:0];
        run_word_s     = word_sum_s[CW] ? SAT : word_sum_s[CW-1:0];
        accept_s       = smp_vld & ~clr;
        win_end_s      = (wcnt_q == WC_LAST);
        lead_hi_done_s = trans_s & prev_q & ~first_q;
    end

    // Next-state for window accumulators, run tracking and result registers.
    always_comb begin
        prev_d    = prev_q;
        first_d   = first_q;
        run_d     = run_q;
        acc_r_d   = acc_r_q;
        acc_1_d   = acc_1_q;
        wcnt_d    = wcnt_q;
        freq_d    = freq_q;
        duty_d    = duty_q;
        t_hi_d    = t_hi_q;
        t_lo_d    = t_lo_q;
        res_vld_d = 1'b0;
        if (clr) begin
            acc_r_d = {CW{1'b0}};
            acc_1_d = {CW{1'b0}};
            wcnt_d  = {WC_W{1'b0}};
            run_d   = {CW{1'b0}};
            first_d = 1'b1;
        end else if (smp_vld) begin
            prev_d = smp[W-1];
            if (trans_s) begin
                run_d   = CW'(trail_len_s);
                first_d = 1'b0;
                // An interior run always ends later in the word than the leading run.
                if (int_hi_s != {CNT_W{1'b0}}) begin
                    t_hi_d = CW'(int_hi_s);
                end else if (prev_q && !first_q) begin
                    t_hi_d = lead_run_s;
                end else begin
                    t_hi_d = t_hi_q;
                end
                if (int_lo_s != {CNT_W{1'b0}}) begin
                    t_lo_d = CW'(int_lo_s);
                end else if (!prev_q && !first_q) begin
                    t_lo_d = lead_run_s;
                end else begin
                    t_lo_d = t_lo_q;
                end
            end else begin
                run_d = run_word_s;
            end
            if (win_end_s) begin
                freq_d    = acc_r_q + CW'(rise_cnt_s);
                duty_d    = acc_1_q + CW'(ones_cnt_s);
                acc_r_d   = {CW{1'b0}};
                acc_1_d   = {CW{1'b0}};
                wcnt_d    = {WC_W{1'b0}};
                res_vld_d = 1'b1;
            end else begin
                acc_r_d = acc_r_q + CW'(rise_cnt_s);
                acc_1_d = acc_1_q + CW'(ones_cnt_s);
                wcnt_d  = wcnt_q + WC_W'(1);
            end
        end else begin
            res_vld_d = 1'b0;
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= 1'b0;
            first_q   <= 1'b1;
            run_q     <= {CW{1'b0}};
            acc_r_q   <= {CW{1'b0}};
            acc_1_q   <= {CW{1'b0}};
            wcnt_q    <= {WC_W{1'b0}};
            freq_q    <= {CW{1'b0}};
            duty_q    <= {CW{1'b0}};
            t_hi_q    <= {CW{1'b0}};
            t_lo_q    <= {CW{1'b0}};
            res_vld_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            first_q   <= first_d;
            run_q     <= run_d;
            acc_r_q   <= acc_r_d;
            acc_1_q   <= acc_1_d;
            wcnt_q    <= wcnt_d;
            freq_q    <= freq_d;
            duty_q    <= duty_d;
            t_hi_q    <= t_hi_d;
            t_lo_q    <= t_lo_d;
            res_vld_q <= res_vld_d;
        end
    end

    assign freq    = freq_q;
    assign duty    = duty_q;
    assign t_hi    = t_hi_q;
    assign t_lo    = t_lo_q;
    assign res_vld = res_vld_q;

`ifdef SIG_METER_MINMAX_EN
    logic [CW-1:0] min_trk_q, min_trk_d, max_trk_q, max_trk_d;
    logic [CW-1:0] hi_min_q, hi_min_d, hi_max_q, hi_max_d;
    logic [CW-1:0] wmin_s, wmax_s;

    // Fold this word's completed high runs into the window extremes.
    always_comb begin
        wmin_s = min_trk_q;
        wmax_s = max_trk_q;
        if (accept_s && lead_hi_done_s) begin
            wmin_s = (lead_run_s < wmin_s) ? lead_run_s : wmin_s;
            wmax_s = (lead_run_s > wmax_s) ? lead_run_s : wmax_s;
        end else begin
            wmin_s = wmin_s;
        end
        if (accept_s && (int_hi_max_s != {CNT_W{1'b0}})) begin
            wmin_s = (CW'(int_hi_min_s) < wmin_s) ? CW'(int_hi_min_s) : wmin_s;
            wmax_s = (CW'(int_hi_max_s) > wmax_s) ? CW'(int_hi_max_s) : wmax_s;
        end else begin
            wmax_s = wmax_s;
        end
    end

    // Latch extremes at window end; an empty window reports zero for both.
    always_comb begin
        min_trk_d = min_trk_q;
        max_trk_d = max_trk_q;
        hi_min_d  = hi_min_q;
        hi_max_d  = hi_max_q;
        if (clr) begin
            min_trk_d = SAT;
            max_trk_d = {CW{1'b0}};
        end else if (smp_vld && win_end_s) begin
            hi_min_d  = (wmax_s == {CW{1'b0}}) ? {CW{1'b0}} : wmin_s;
            hi_max_d  = wmax_s;
            min_trk_d = SAT;
            max_trk_d = {CW{1'b0}};
        end else if (smp_vld) begin
            min_trk_d = wmin_s;
            max_trk_d = wmax_s;
        end else begin
            min_trk_d = min_trk_q;
        end
    end

    // Min/max tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_trk_q <= SAT;
            max_trk_q <= {CW{1'b0}};
            hi_min_q  <= {CW{1'b0}};
            hi_max_q  <= {CW{1'b0}};
        end else begin
            min_trk_q <= min_trk_d;
            max_trk_q <= max_trk_d;
            hi_min_q  <= hi_min_d;
            hi_max_q  <= hi_max_d;
        end
    end

    assign hi_min = hi_min_q;
    assign hi_max = hi_max_q;
`else
    assign hi_min = {CW{1'b0}};
    assign hi_max = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_sig_meter.sv
// Self-checking bench for sig_meter (W=8, GATE=4, CW=16) with a sample-serial reference model.
module tb_sig_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        smp_vld = 1'b0;
    logic [7:0]  smp = 8'h00;
    logic        clr = 1'b0;
    logic [15:0] freq, duty, t_hi, t_lo, hi_min, hi_max;
    logic        res_vld;

    int checks = 0;
    int failures = 0;

    // Reference model state: the stream is processed one sample at a time.
    logic        m_prev;
    logic        m_armed;
    int          m_run;
    int          m_accr, m_acc1, m_wcnt;
    logic [15:0] m_freq, m_duty, m_thi, m_tlo, m_min, m_max;
    logic        m_res;
    int          hq[$];

    sig_meter #(.W(8), .GATE(32'd4), .CW(16)) dut (
        .clk(clk), .rst(rst), .smp_vld(smp_vld), .smp(smp), .clr(clr),
        .freq(freq), .duty(duty), .t_hi(t_hi), .t_lo(t_lo),
        .hi_min(hi_min), .hi_max(hi_max), .res_vld(res_vld)
    );

    always #5 clk = ~clk;

    task automatic model_rst();
        m_prev = 1'b0; m_armed = 1'b1; m_run = 0;
        m_accr = 0; m_acc1 = 0; m_wcnt = 0;
        m_freq = 16'd0; m_duty = 16'd0; m_thi = 16'd0; m_tlo = 16'd0;
        m_min = 16'd0; m_max = 16'd0; m_res = 1'b0;
        hq.delete();
    endtask

    task automatic model_clr();
        m_accr = 0; m_acc1 = 0; m_wcnt = 0; m_run = 0; m_armed = 1'b1;
        hq.delete();
    endtask

    task automatic model_word(input logic [7:0] w);
        logic s;
        for (int i = 0; i < 8; i++) begin
            s = w[i];
            if (s != m_prev) begin
                if (!m_armed) begin
                    if (m_prev) begin
                        m_thi = m_run[15:0];
                        hq.push_back(m_run);
                    end else begin
                        m_tlo = m_run[15:0];
                    end
                end
                m_armed = 1'b0;
                if (s) m_accr++;
                m_run = 1;
            end else if (m_run < 65535) begin
                m_run++;
            end
            if (s) m_acc1++;
            m_prev = s;
        end
        m_wcnt++;
        if (m_wcnt == 4) begin
            m_freq = m_accr[15:0];
            m_duty = m_acc1[15:0];
            m_res  = 1'b1;
            if (hq.size() == 0) begin
                m_min = 16'd0; m_max = 16'd0;
            end else begin
                m_min = 16'hFFFF; m_max = 16'd0;
                foreach (hq[k]) begin
                    if (hq[k] < m_min) m_min = hq[k][15:0];
                    if (hq[k] > m_max) m_max = hq[k][15:0];
                end
            end
            hq.delete();
            m_accr = 0; m_acc1 = 0; m_wcnt = 0;
        end
    endtask

    // Apply one cycle of inputs from a negedge; return at the following negedge.
    task automatic cycle(input logic v, input logic [7:0] w, input logic c);
        smp_vld = v; smp = w; clr = c;
        @(posedge clk);
        m_res = 1'b0;
        if (c) model_clr();
        else if (v) model_word(w);
        @(negedge clk);
        smp_vld = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; smp_vld = 1'b0; clr = 1'b0; smp = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_rst();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (freq !== 16'd0 || duty !== 16'd0) begin failures++; $display("FAIL reset_fd freq=%0d duty=%0d exp=0", freq, duty); end
        checks++; if (t_hi !== 16'd0 || t_lo !== 16'd0) begin failures++; $display("FAIL reset_t t_hi=%0d t_lo=%0d exp=0", t_hi, t_lo); end
        checks++; if (res_vld !== 1'b0 || hi_min !== 16'd0 || hi_max !== 16'd0) begin failures++; $display("FAIL reset_misc res_vld=%b hi_min=%0d hi_max=%0d exp=0", res_vld, hi_min, hi_max); end
        rst = 1'b0;
        model_rst();
    endtask

    task automatic test_zeros();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'h00, 1'b0);
            checks++; if (res_vld !== (i == 3)) begin failures++; $display("FAIL zeros_vld word=%0d got=%b exp=%b", i, res_vld, (i == 3)); end
        end
        checks++; if (freq !== 16'd0 || duty !== 16'd0 || t_hi !== 16'd0 || t_lo !== 16'd0) begin failures++; $display("FAIL zeros_val got=%0d/%0d/%0d/%0d exp=0/0/0/0", freq, duty, t_hi, t_lo); end
        cycle(1'b0, 8'h00, 1'b0);
        checks++; if (res_vld !== 1'b0) begin failures++; $display("FAIL zeros_pulse got=%b exp=0", res_vld); end
    endtask

    task automatic test_0f();
        do_reset();
        cycle(1'b1, 8'h0F, 1'b0);
        checks++; if (t_hi !== 16'd4 || t_lo !== 16'd0) begin failures++; $display("FAIL 0f_w1 t_hi=%0d t_lo=%0d exp=4/0", t_hi, t_lo); end
        cycle(1'b1, 8'h0F, 1'b0);
        checks++; if (t_lo !== 16'd4) begin failures++; $display("FAIL 0f_w2 t_lo=%0d exp=4", t_lo); end
        cycle(1'b1, 8'h0F, 1'b0);
        cycle(1'b1, 8'h0F, 1'b0);
        checks++; if (freq !== 16'd4 || duty !== 16'd16 || res_vld !== 1'b1) begin failures++; $display("FAIL 0f_win freq=%0d duty=%0d vld=%b exp=4/16/1", freq, duty, res_vld); end
    endtask

    task automatic test_long_high();
        logic [7:0] seq [5];
        seq = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, seq[i], 1'b0);
            if (i == 3) begin
                checks++; if (res_vld !== 1'b1 || freq !== 16'd1 || duty !== 16'd24 || t_hi !== 16'd0) begin failures++; $display("FAIL long_win vld=%b freq=%0d duty=%0d t_hi=%0d exp=1/1/24/0", res_vld, freq, duty, t_hi); end
            end
        end
        checks++; if (t_hi !== 16'd24) begin failures++; $display("FAIL long_thi got=%0d exp=24", t_hi); end
    endtask

    task automatic test_55();
        do_reset();
        repeat (8) cycle(1'b1, 8'h55, 1'b0);
        checks++; if (freq !== 16'd16 || duty !== 16'd16 || t_hi !== 16'd1 || t_lo !== 16'd1) begin failures++; $display("FAIL alt_val got=%0d/%0d/%0d/%0d exp=16/16/1/1", freq, duty, t_hi, t_lo); end
`ifdef SIG_METER_MINMAX_EN
        checks++; if (hi_min !== 16'd1 || hi_max !== 16'd1) begin failures++; $display("FAIL alt_minmax got=%0d/%0d exp=1/1", hi_min, hi_max); end
`else
        checks++; if (hi_min !== 16'd0 || hi_max !== 16'd0) begin failures++; $display("FAIL alt_minmax got=%0d/%0d exp=0/0", hi_min, hi_max); end
`endif
    endtask

    task automatic test_clr();
        do_reset();
        cycle(1'b1, 8'h0F, 1'b0);
        cycle(1'b1, 8'h0F, 1'b0);
        cycle(1'b1, 8'h0F, 1'b1);
        checks++; if (res_vld !== 1'b0) begin failures++; $display("FAIL clr_drop got=%b exp=0", res_vld); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'h0F, 1'b0);
            checks++; if (res_vld !== (i == 3)) begin failures++; $display("FAIL clr_vld word=%0d got=%b exp=%b", i, res_vld, (i == 3)); end
            repeat (3) cycle(1'b0, 8'hA5, 1'b0);
        end
        checks++; if (freq !== 16'd4 || duty !== 16'd16 || res_vld !== 1'b0) begin failures++; $display("FAIL clr_val freq=%0d duty=%0d vld=%b exp=4/16/0", freq, duty, res_vld); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        repeat (5) cycle(1'b1, 8'h0F, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (freq !== 16'd0 || duty !== 16'd0 || t_hi !== 16'd0 || t_lo !== 16'd0 || res_vld !== 1'b0) begin failures++; $display("FAIL rst_mid got=%0d/%0d/%0d/%0d/%b exp=0", freq, duty, t_hi, t_lo, res_vld); end
        @(negedge clk);
        rst = 1'b0;
        model_rst();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'hFF, 1'b0);
            checks++; if (res_vld !== (i == 3)) begin failures++; $display("FAIL rst_vld word=%0d got=%b exp=%b", i, res_vld, (i == 3)); end
        end
    endtask

    task automatic test_random();
        logic [7:0] w;
        logic       v, c;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       w = 8'h00;
                1:       w = 8'hFF;
                default: w = 8'($urandom);
            endcase
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 39) == 0);
            cycle(v, w, c);
            checks++;
            if (freq !== m_freq || duty !== m_duty || t_hi !== m_thi || t_lo !== m_tlo || res_vld !== m_res) begin
                failures++;
                $display("FAIL rand_main n=%0d got=%0d/%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%0d/%b", n, freq, duty, t_hi, t_lo, res_vld, m_freq, m_duty, m_thi, m_tlo, m_res);
            end
`ifdef SIG_METER_MINMAX_EN
            checks++;
            if (hi_min !== m_min || hi_max !== m_max) begin failures++; $display("FAIL rand_minmax n=%0d got=%0d/%0d exp=%0d/%0d", n, hi_min, hi_max, m_min, m_max); end
`endif
        end
    endtask

    initial begin
        model_rst();
        @(negedge clk);
        test_reset();
        test_zeros();
        test_0f();
        test_long_high();
        test_55();
        test_clr();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sig_meter.md
# sig_meter

Parametrised successor to the single-channel frequency/duty counter. It consumes a stream of W-sample parallel words from the deserialiser and measures signal statistics over a gate window of GATE accepted words: rising-edge count (frequency), high-sample count (duty), and the most recent completed high and low pulse widths. Unlike the previous counter, it handles any number of transitions per word, pulse widths spanning many words, and gaps in the sample stream. It also provides a synchronous window restart. It sits between the sample deserialiser and the display/page mux.

## Interface
- W, 32, samples per input word; bit 0 is the oldest sample and bit W-1 the newest.
- GATE, 31_250_000, accepted words per measurement window (≥1).
- CW, 32, width of every count/width output; must satisfy GATE*W < 2^CW.
- clk  in  1  sample-word clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- smp_vld  in  1  smp carries a valid word this cycle.
- smp  in  W  sample word.
- clr  in  1  synchronous window restart.
- freq  out  CW  rising edges in the last completed window.
- duty  out  CW  high samples in the last completed window.
- t_hi  out  CW  length in samples of the most recently completed high run.
- t_lo  out  CW  length in samples of the most recently completed low run.
- hi_min, hi_max  out  CW each  extremes of completed high runs in the last window (see Configuration).
- res_vld  out  1  one-cycle pulse when window results update.

## Operation
- Stream model: accepted words are concatenated oldest-first. The previous sample `prev` is the last accepted word's bit W-1; reset value is 0.
- Rising edge: sample i =1 while its predecessor (bit i-1, or `prev` for i=0) is 0. A falling edge is the converse.
- Window accumulators `acc_r` (rises) and `acc_1` (ones) sum per-word counts. `wcnt` counts accepted words from 0 to GATE-1.
- On the accepted word that makes wcnt reach GATE:
  - freq, duty ← accumulator plus this word's counts.
  - Accumulators restart with 0; wcnt ← 0; res_vld=1 for one cycle.
- Run tracking:
  - `run` holds the length of the current open run, carried across words.
  - A word with no transitions adds W to `run`, saturating at 2^CW-1.
  - At each transition, the run ending there completes with length = samples since the previous transition (including carried `run`). Within one word, t_hi/t_lo take the last completed run of each level; earlier ones in the word are superseded.
- The first run after rst or clr has an unknown start. Its completion is discarded: t_hi/t_lo do not update, and it is not used for min/max.
- Idle cycles (smp_vld=0) change nothing; gate time counts words, not cycles.
- clr:
  - Zeroes the accumulators, wcnt and run, and re-arms first-run discard.
  - freq/duty/t_hi/t_lo keep their values; `prev` is retained.
  - If clr and smp_vld are both high, clr wins and the word is dropped.
- Saturation: run and width outputs saturate at 2^CW-1. Accumulators cannot overflow given the CW rule.

## Timing
- Reset: all outputs 0, res_vld 0, wcnt 0, run 0, prev 0, first-run discard armed.
- rst mid-window aborts the window with no res_vld.
- Latency:
  - Results are registered on the same posedge that accepts the GATE-th word; res_vld is high for the following cycle only.
  - t_hi/t_lo update on the posedge accepting the word containing the terminating transition.
- GATE=1: res_vld follows every accepted word.
- Back-to-back windows with smp_vld held high lose no words.

## Configuration
- SIG_METER_MINMAX_EN defined:
  - hi_min/hi_max track completed high runs within the window.
  - They are latched with freq/duty at window end.
  - Tracking resets at window start, with min ← all-ones and max ← 0.
  - A window with no completed high run reports hi_min=0 and hi_max=0.
- Not defined: hi_min/hi_max are driven constant 0 and no tracking logic is built.

## Structure
- Shared package meter_pkg:
  - `u32` typedef.
  - Default constants W_DEF=32 and GATE_DEF=31_250_000.
- Sub-module word_stats (combinational, parameter W):
  - Inputs: prev, smp.
  - Outputs: rise count, ones count, transition flag, leading-run length, trailing-run length, last complete interior high/low run lengths, plus, under the macro, min/max interior high runs.
- sig_meter holds all registers and the window control.

## Test plan
All scenarios use W=8, GATE=4, CW=16.
- Four words of 8'h00 after rst → freq=0, duty=0, t_hi=t_lo=0, one res_vld pulse on the 5th cycle.
- Repeat 8'h0F (bits 0–3 high) → first window freq=4, duty=16; t_hi=4 after word 1, t_lo=4 after word 2 (first low run discarded).
- Words 8'h00, 8'hFF×3, 8'h00 → t_hi=24, updated on the 5th word; res_vld after the 4th word.
- Repeat 8'h55 → freq=16, duty=16, t_hi=t_lo=1; with SIG_METER_MINMAX_EN, hi_min=hi_max=1.
- 8'h0F×2, then clr together with smp_vld, then 8'h0F×4 → res_vld only after the 4 post-clr words, with freq=4, duty=16. Idle gaps of 3 cycles between words do not change the results.
- rst asserted after 2 words of 8'hFF → all outputs 0 immediately; no res_vld until 4 further words are accepted.
